sram_fifo: RTL

//  Deep FIFO that drives an external 1r1w SRAM macro (fakeram_1r1w_* family) as its

---
 rtl/sram_fifo.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sram_fifo.sv
// Deep FIFO backed by an external 1r1w SRAM macro, with a 2-entry show-ahead
// prefetch buffer that hides the macro's one-cycle read latency.
module sram_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SIZE       = 128,
    parameter int unsigned ADDR_WIDTH = $clog2(SIZE),
    parameter int unsigned CNT_WIDTH  = $clog2(SIZE + 3)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  sram_read_en,
    output logic [ADDR_WIDTH-1:0] sram_read_addr,
    input  logic [DATA_WIDTH-1:0] sram_read_data,
    output logic                  sram_write_en,
    output logic [ADDR_WIDTH-1:0] sram_write_addr,
    output logic [DATA_WIDTH-1:0] sram_write_data
);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  sram_cnt_q, sram_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

    logic                  deq;
    logic                  enq;
    logic                  bypass;
    logic                  capture;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic [2:0]            credit;
    logic [1:0]            buf_fill;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == ADDR_WIDTH'(SIZE - 1)) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    // Handshakes and SRAM requests depend only on registered state plus flush/out_ready.
    assign in_ready  = (sram_cnt_q != CNT_WIDTH'(SIZE)) & ~flush;
    assign out_valid = (buf_cnt_q != 2'd0);
    assign out_data  = buf0_q;
    assign count     = sram_cnt_q + CNT_WIDTH'(inflight_q) + CNT_WIDTH'(buf_cnt_q);

    assign deq    = out_valid & out_ready;
    assign enq    = in_valid & in_ready;
    assign bypass = enq & (sram_cnt_q == '0) & ~inflight_q & ((buf_cnt_q < 2'd2) | deq);

    // Buffer credit: a read is only issued if its data is guaranteed a slot next cycle.
    assign credit       = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(deq);
    assign sram_read_en = ~flush & (sram_cnt_q != '0) & (credit < 3'd2);
    assign sram_read_addr = rd_ptr_q;

    assign sram_write_en   = enq & ~bypass;
    assign sram_write_addr = wr_ptr_q;
    assign sram_write_data = in_data;

    assign capture   = inflight_q & ~flush;
    assign push      = capture | bypass;
    assign push_data = capture ? sram_read_data : in_data;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sram_cnt_d = sram_cnt_q + CNT_WIDTH'(sram_write_en) - CNT_WIDTH'(sram_read_en);
        inflight_d = sram_read_en;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        buf_fill   = buf_cnt_q;

        if (sram_write_en) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (sram_read_en)  rd_ptr_d = ptr_inc(rd_ptr_q);

        // Shift the head out first, then append at the first free slot.
        if (deq) begin
            buf0_d   = buf1_q;
            buf_fill = buf_cnt_q - 2'd1;
        end
        if (push) begin
            if (buf_fill == 2'd0) buf0_d = push_data;
            else                  buf1_d = push_data;
            buf_fill = buf_fill + 2'd1;
        end
        buf_cnt_d = buf_fill;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            sram_cnt_d = '0;
            inflight_d = 1'b0;
            buf_cnt_d  = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sram_cnt_q <= '0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sram_cnt_q <= sram_cnt_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

endmodule
